// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and helpers for the MMIO UART transmitter.
//   tx_state_t : serialiser FSM states
//   DATA_BITS  : payload bits per frame (8N1)
//   baud_div() : clock cycles per serial bit, truncated
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, shared by the UART TX and RX sides.
//   clk, rst     : clock, asynchronous active-high reset
//   push, wdata  : enqueue request and data (ignored when full unless popping)
//   pop, rdata   : dequeue request (ignored when empty); rdata shows the head
//   full, empty  : occupancy flags, combinational from count
//   count        : number of stored entries (0..DEPTH)
module mmio_uart_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the head slot, so a push at full is legal.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: queues CPU-written bytes and sends them 8N1, LSB first.
//   clk, rst   : system clock, asynchronous active-high reset (released synchronously)
//   data_in    : byte from the MMIO data register, sampled on the doorbell edge
//   doorbell   : level flag; each rising edge enqueues data_in once
//   tx         : serial line, idle high, driven straight from a flop
//   tx_busy    : frame in progress or bytes still queued
//   fifo_full  : queue holds FIFO_DEPTH bytes
//   overflow   : sticky, a byte was dropped because the queue was full
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       doorbell,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             db_q;

    logic             push_req;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full_w;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;
    logic             bit_done;

    assign push_req = doorbell & ~db_q;
    assign bit_done = (cnt_q == CNT_LAST);

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (data_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full_w),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = StStop;
                    else                            bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the current state one cycle later, keeping tx a clean flop.
        case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase

        // A push at full is dropped unless the head leaves in the same cycle.
        overflow_d = overflow_q | (push_req & fifo_full_w & ~fifo_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            db_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            db_q       <= doorbell;
        end
    end

    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign fifo_full = (fifo_count == FULL_CNT);
    assign tx_busy   = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       doorbell;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .doorbell  (doorbell),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        doorbell = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Push lands on the next rising edge; returns one negedge after that edge + 1.
    task automatic push_byte(input logic [7:0] b);
        data_in = b;
        doorbell = 1'b1;
        @(negedge clk);
        doorbell = 1'b0;
        @(negedge clk);
    endtask

    // Decodes one frame from negedge samples; DIV=10, so each bit is 10 samples.
    task automatic capture_frame(input int budget, output logic [7:0] data,
                                 output int bad, output bit timed_out);
        logic s [100];
        int waited;
        waited = 0;
        data = 8'h00;
        bad = 0;
        timed_out = 1'b0;
        while (tx !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            timed_out = 1'b1;
        end else begin
            for (int i = 0; i < 100; i++) begin
                s[i] = tx;
                @(negedge clk);
            end
            for (int w = 0; w < 10; w++)
                for (int k = 1; k < 10; k++)
                    if (s[10*w+k] !== s[10*w]) bad++;
            if (s[90] !== 1'b1) bad++;
            for (int i = 0; i < 8; i++) data[i] = s[10*(i+1)];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        doorbell = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [7:0] pat;
        pat = 8'h55;
        do_reset();
        data_in = pat;
        doorbell = 1'b1;
        @(negedge clk);  // after push edge N
        doorbell = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_n0_tx: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", tx_busy); end
        @(negedge clk);  // N+1: pop
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_n1_tx: got %b want 1", tx); end
        @(negedge clk);  // N+2: start bit begins
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_n2_tx: got %b want 0", tx); end
        repeat (5) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_mid: got %b want 0", tx); end
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            checks++;
            if (tx !== pat[i]) begin
                errors++;
                $display("FAIL single_bit%0d: got %b want %b", i, tx, pat[i]);
            end
        end
        repeat (10) @(negedge clk);  // N+97: middle of stop bit
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_stop: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b want 1", tx_busy); end
        repeat (5) @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", tx_busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b want 1", tx); end
    endtask

    task automatic test_held_doorbell();
        logic [7:0] got;
        int bad;
        bit to;
        int lows;
        lows = 0;
        do_reset();
        data_in = 8'hA3;
        doorbell = 1'b1;
        capture_frame(20, got, bad, to);
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        doorbell = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        checks++; if (to) begin errors++; $display("FAIL held_timeout: got no frame want one"); end
        checks++; if (got !== 8'hA3) begin errors++; $display("FAIL held_data: got %h want a3", got); end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_framing: got %0d bad windows want 0", bad); end
        checks++; if (lows != 0) begin errors++; $display("FAIL held_extra_frame: got %0d low samples want 0", lows); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL held_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] got [5];
        int bads [5];
        bit tos [5];
        int lows;
        lows = 0;
        do_reset();
        fork
            begin
                for (int b = 1; b <= 5; b++) push_byte(8'(b));
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
                repeat (20) @(negedge clk);
                push_byte(8'h06);
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
            end
            begin
                for (int f = 0; f < 5; f++) capture_frame(300, got[f], bads[f], tos[f]);
            end
        join
        for (int f = 0; f < 5; f++) begin
            checks++;
            if (tos[f] || got[f] !== 8'(f + 1) || bads[f] != 0) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %h (timeout %0d, bad %0d) want %h", f, got[f], tos[f],
                         bads[f], 8'(f + 1));
            end
        end
        repeat (150) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL ovf_dropped_sent: got %0d low samples want 0", lows); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] got [6];
        int bads [6];
        bit tos [6];
        do_reset();
        fork
            begin
                for (int b = 1; b <= 5; b++) push_byte(8'(b));  // pushes at N..N+8
                repeat (92) @(negedge clk);                      // after N+101
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ppf_pre_full: got %b want 1", fifo_full); end
                data_in = 8'h06;
                doorbell = 1'b1;                                 // push lands on pop edge N+102
                @(negedge clk);
                doorbell = 1'b0;
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ppf_full: got %b want 1", fifo_full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ppf_ovf: got %b want 0", overflow); end
            end
            begin
                for (int f = 0; f < 6; f++) capture_frame(300, got[f], bads[f], tos[f]);
            end
        join
        for (int f = 0; f < 6; f++) begin
            checks++;
            if (tos[f] || got[f] !== 8'(f + 1) || bads[f] != 0) begin
                errors++;
                $display("FAIL ppf_frame%0d: got %h (timeout %0d, bad %0d) want %h", f, got[f], tos[f],
                         bads[f], 8'(f + 1));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        lows = 0;
        do_reset();
        push_byte(8'h00);       // push at N
        push_byte(8'hAA);       // push at N+2, stays queued
        repeat (43) @(negedge clk);  // after N+46: data bit 3 on the line
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx: got %b want 0", tx); end
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_resumed: got %0d low samples want 0", lows); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_end: got %b want 0", tx_busy); end
    endtask

    task automatic test_random_stream();
        logic [7:0] got, b, want;
        int bad, guard;
        bit to;
        do_reset();
        exp_q.delete();
        fork
            begin
                for (int n = 0; n < 64; n++) begin
                    guard = 0;
                    while (fifo_full === 1'b1 && guard < 1000) begin
                        @(negedge clk);
                        guard++;
                    end
                    b = 8'($urandom_range(0, 255));
                    exp_q.push_back(b);
                    push_byte(b);
                    repeat ($urandom_range(0, 40)) @(negedge clk);
                end
            end
            begin
                for (int n = 0; n < 64; n++) begin
                    capture_frame(2000, got, bad, to);
                    checks++;
                    if (to) begin
                        errors++;
                        $display("FAIL rand_timeout: frame %0d got none want one", n);
                        break;
                    end
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_spurious: frame %0d got %h want no frame", n, got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL rand_data: frame %0d got %h want %h", n, got, want);
                        end
                    end
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL rand_framing: frame %0d got %0d bad windows want 0", n, bad);
                    end
                end
            end
        join
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_left: got %0d unsent want 0", exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf: got %b want 0", overflow); end
    endtask

    initial begin
        rst = 1'b1;
        doorbell = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_single_frame();
        test_held_doorbell();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
